mem_bus_arbiter: RTL and testbench

//   Shares one single-port synchronous memory between the core's instruction-fetch

---
 rtl/mem_bus_arbiter_if.sv | 57 +++++
 rtl/mem_bus_arbiter.sv | 95 +++++++++
 tb/tb_mem_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : IF/LS request ports and memory port of the shared-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [STRB_W-1:0] ls_wstrb;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_ce, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    // Core ports plus memory
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : IF/LS arbiter for one single-port sync memory, LS priority
//               with bounded IF starvation; read data routed back next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_bus_arbiter_if.slave   bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

    logic w_ls_win;
    logic w_if_win;

    always_comb begin
        w_ls_win = !rst && bus.ls_req && (starve_q < MAX_CNT);
        w_if_win = !rst && bus.if_req && (!bus.ls_req || (starve_q == MAX_CNT));

        bus.mem_ce    = w_ls_win || w_if_win;
        bus.mem_we    = w_ls_win && bus.ls_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (w_ls_win) begin
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
            bus.mem_wstrb = bus.ls_we ? bus.ls_wstrb : {STRB_W{1'b0}};
        end else if (w_if_win) begin
            bus.mem_addr  = bus.if_addr;
        end

        // IF waiting only counts while it actually has a request pending
        starve_d = '0;
        if (w_ls_win && bus.if_req) begin
            starve_d = (starve_q == MAX_CNT) ? MAX_CNT : starve_q + 1'b1;
        end

        owner_d = OWN_NONE;
        if (w_if_win) begin
            owner_d = OWN_IF;
        end else if (w_ls_win && !bus.ls_we) begin
            owner_d = OWN_LS;
        end
    end

    assign bus.if_gnt = w_if_win;
    assign bus.ls_gnt = w_ls_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (owner_q == OWN_IF) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (owner_q == OWN_LS) begin
                ls_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Memory data arrives in the response cycle; the register holds it afterwards
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.ls_rvalid = (owner_q == OWN_LS);
    assign bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_rdata : if_rdata_q;
    assign bus.ls_rdata  = (owner_q == OWN_LS) ? bus.mem_rdata : ls_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed and constrained-random bench for mem_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [31:0] mem [256];
    logic [31:0] mem_rdata_r = '0;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: word i starts as 32'hC0DE00ii
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= {16'hC0DE, 8'h00, 8'(i)};
        end else if (bus.mem_ce) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                mem_rdata_r <= mem[bus.mem_addr[9:2]];
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
        bus.ls_wdata = '0; bus.ls_wstrb = '0;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        bus.ls_req = 1'b1; bus.ls_addr = 32'h8;
        @(negedge clk);
        tests_run++;
        if (bus.if_gnt !== 1'b0 || bus.ls_gnt !== 1'b0 || bus.mem_ce !== 1'b0 || bus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_gnt: if_gnt=%b ls_gnt=%b ce=%b we=%b, want all 0", bus.if_gnt, bus.ls_gnt, bus.mem_ce, bus.mem_we);
        end
        tests_run++;
        if (bus.if_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0 || bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out: if_rv=%b ls_rv=%b if_rd=%h ls_rd=%h addr=%h, want zeros", bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata, bus.mem_addr);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        mem_init = 1'b0;
    endtask

    task automatic test_if_only();
        logic [31:0] addrs [3];
        logic [31:0] exp_d [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        exp_d = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002};
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin bus.if_req = 1'b1; bus.if_addr = addrs[k]; end
            else       begin bus.if_req = 1'b0; bus.if_addr = '0; end
            @(negedge clk);
            tests_run++;
            if (k < 3 && (bus.if_gnt !== 1'b1 || bus.ls_gnt !== 1'b0 || bus.mem_addr !== addrs[k] || bus.mem_we !== 1'b0)) begin
                tests_failed++;
                $display("FAIL if_only_gnt[%0d]: if_gnt=%b ls_gnt=%b addr=%h we=%b, want 1 0 %h 0", k, bus.if_gnt, bus.ls_gnt, bus.mem_addr, bus.mem_we, addrs[k]);
            end else if (k == 3 && (bus.if_gnt !== 1'b0 || bus.mem_ce !== 1'b0 || bus.mem_addr !== 32'h0)) begin
                tests_failed++;
                $display("FAIL if_only_idle: if_gnt=%b ce=%b addr=%h, want 0 0 0", bus.if_gnt, bus.mem_ce, bus.mem_addr);
            end
            if (k > 0) begin
                tests_run++;
                if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== exp_d[k-1] || bus.ls_rvalid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL if_only_data[%0d]: rv=%b data=%h ls_rv=%b, want 1 %h 0", k-1, bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, exp_d[k-1]);
                end
            end
            tick();
        end
        @(negedge clk);
        tests_run++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'hC0DE0002) begin
            tests_failed++;
            $display("FAIL if_only_hold: rv=%b data=%h, want 0 c0de0002", bus.if_rvalid, bus.if_rdata);
        end
        tick();
    endtask

    task automatic test_ls_read();
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h100; bus.ls_wstrb = 4'hF;
        @(negedge clk);
        tests_run++;
        if (bus.ls_gnt !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0) begin
            tests_failed++;
            $display("FAIL ls_read_gnt: gnt=%b addr=%h we=%b strb=%h, want 1 100 0 0", bus.ls_gnt, bus.mem_addr, bus.mem_we, bus.mem_wstrb);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hC0DE0040 || bus.if_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ls_read_data: rv=%b data=%h if_rv=%b, want 1 c0de0040 0", bus.ls_rvalid, bus.ls_rdata, bus.if_rvalid);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.ls_rvalid !== 1'b0 || bus.ls_rdata !== 32'hC0DE0040) begin
            tests_failed++;
            $display("FAIL ls_read_pulse: rv=%b data=%h, want 0 c0de0040", bus.ls_rvalid, bus.ls_rdata);
        end
        tick();
    endtask

    // Both ports held: four LS grants then one IF grant, repeating
    task automatic check_pattern(input string name, input int n);
        logic exp_if, prev_if;
        prev_if = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_if = (k % (MAX_WAIT + 1)) == MAX_WAIT;
            @(negedge clk);
            tests_run++;
            if (bus.if_gnt !== exp_if || bus.ls_gnt !== !exp_if) begin
                tests_failed++;
                $display("FAIL %s_gnt[%0d]: if_gnt=%b ls_gnt=%b, want %b %b", name, k, bus.if_gnt, bus.ls_gnt, exp_if, !exp_if);
            end
            if (k > 0) begin
                tests_run++;
                if (bus.if_rvalid !== prev_if || bus.ls_rvalid !== !prev_if) begin
                    tests_failed++;
                    $display("FAIL %s_rv[%0d]: if_rv=%b ls_rv=%b, want %b %b", name, k, bus.if_rvalid, bus.ls_rvalid, prev_if, !prev_if);
                end
            end
            prev_if = exp_if;
            tick();
        end
    endtask

    task automatic test_contention();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h20;
        check_pattern("contend", 10);
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hC0DE0004 || bus.ls_rdata !== 32'hC0DE0008) begin
            tests_failed++;
            $display("FAIL contend_data: if_rv=%b if_rd=%h ls_rd=%h, want 1 c0de0004 c0de0008", bus.if_rvalid, bus.if_rdata, bus.ls_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h200;
        bus.ls_wdata = 32'hDEADBEEF; bus.ls_wstrb = 4'b0011;
        @(negedge clk);
        tests_run++;
        if (bus.ls_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wstrb !== 4'b0011 || bus.mem_wdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wr_cycle: gnt=%b we=%b strb=%h wdata=%h, want 1 1 3 deadbeef", bus.ls_gnt, bus.mem_we, bus.mem_wstrb, bus.mem_wdata);
        end
        tick();
        bus.ls_we = 1'b0; bus.ls_wdata = '0; bus.ls_wstrb = '0;
        @(negedge clk);
        tests_run++;
        if (bus.ls_rvalid !== 1'b0 || bus.ls_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_no_rvalid: rv=%b gnt=%b, want 0 1", bus.ls_rvalid, bus.ls_gnt);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hC0DEBEEF) begin
            tests_failed++;
            $display("FAIL raw_data: rv=%b data=%h, want 1 c0debeef", bus.ls_rvalid, bus.ls_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.if_req = 1'b1; bus.if_addr = 32'hC;
        @(negedge clk);
        tests_run++;
        if (bus.if_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_gnt: if_gnt=%b, want 1", bus.if_gnt);
        end
        rst = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0 || bus.mem_ce !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_out: if_rv=%b if_rd=%h ls_rd=%h ce=%b, want 0 0 0 0", bus.if_rvalid, bus.if_rdata, bus.ls_rdata, bus.mem_ce);
        end
        tick();
        rst = 1'b0;
        // Build up LS streak, reset in its middle, then expect a cold-start pattern
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h40;
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.ls_rvalid !== 1'b0 || bus.ls_gnt !== 1'b0 || bus.if_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ls: ls_rv=%b ls_gnt=%b if_gnt=%b, want 0 0 0", bus.ls_rvalid, bus.ls_gnt, bus.if_gnt);
        end
        tick();
        rst = 1'b0;
        check_pattern("cold", 5);
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic        if_gnt_s = 1'b0, ls_gnt_s = 1'b0;
        logic        exp_if_rv = 1'b0, exp_ls_rv = 1'b0;
        logic [31:0] exp_if_d = '0, exp_ls_d = '0;
        int          wait_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.if_req || if_gnt_s) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!bus.ls_req || ls_gnt_s) begin
                bus.ls_req   = ($urandom_range(0, 2) != 0);
                bus.ls_we    = ($urandom_range(0, 2) == 0);
                bus.ls_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                bus.ls_wdata = $urandom;
                bus.ls_wstrb = 4'($urandom);
            end
            @(negedge clk);
            tests_run++;
            if ((bus.if_gnt && bus.ls_gnt) || ((bus.if_req || bus.ls_req) !== (bus.if_gnt || bus.ls_gnt))) begin
                tests_failed++;
                $display("FAIL rnd_gnt[%0d]: if_req=%b ls_req=%b if_gnt=%b ls_gnt=%b", i, bus.if_req, bus.ls_req, bus.if_gnt, bus.ls_gnt);
            end
            tests_run++;
            if (bus.if_rvalid !== exp_if_rv || (exp_if_rv && bus.if_rdata !== exp_if_d)) begin
                tests_failed++;
                $display("FAIL rnd_if_rv[%0d]: rv=%b data=%h, want %b %h", i, bus.if_rvalid, bus.if_rdata, exp_if_rv, exp_if_d);
            end
            tests_run++;
            if (bus.ls_rvalid !== exp_ls_rv || (exp_ls_rv && bus.ls_rdata !== exp_ls_d)) begin
                tests_failed++;
                $display("FAIL rnd_ls_rv[%0d]: rv=%b data=%h, want %b %h", i, bus.ls_rvalid, bus.ls_rdata, exp_ls_rv, exp_ls_d);
            end
            wait_cnt = (bus.if_req && !bus.if_gnt) ? wait_cnt + 1 : 0;
            tests_run++;
            if (wait_cnt > MAX_WAIT) begin
                tests_failed++;
                $display("FAIL rnd_starve[%0d]: if waited %0d cycles, want <= %0d", i, wait_cnt, MAX_WAIT);
            end
            exp_if_rv = bus.if_gnt;
            exp_if_d  = mem[bus.if_addr[9:2]];
            exp_ls_rv = bus.ls_gnt && !bus.ls_we;
            exp_ls_d  = mem[bus.ls_addr[9:2]];
            if_gnt_s  = bus.if_gnt;
            ls_gnt_s  = bus.ls_gnt;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        repeat (2) tick();
        test_reset();
        test_if_only();
        test_ls_read();
        test_contention();
        test_write_read();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
